// File: rtl/firebird7_in_gate1_tessent_pkg.sv
// Shared constants and types for the firebird7_in_gate1 IJTAG test data registers.
package firebird7_in_gate1_tessent_pkg;
  localparam int TDR_W19_WIDTH = 19;
  localparam int TDR_SEL_BIT   = TDR_W19_WIDTH;

  typedef struct packed {
    logic        sel;
    logic [18:0] data;
  } tdr_w19_t;
endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_cell.sv
// One bit slice of an IJTAG TDR: shift/capture flop plus its update-stage flop.
module firebird7_in_gate1_tessent_tdr_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic ce,
  input  logic se,
  input  logic ue,
  input  logic si,
  input  logic cap,
  output logic shift_q,
  output logic upd_q
);
  // Update samples the pre-edge shift bit, so a same-edge shift/capture does not leak through.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= 1'b0;
      upd_q   <= RESET_VAL;
    end else if (sel) begin
      if (ce)      shift_q <= cap;
      else if (se) shift_q <= si;
      if (ue)      upd_q   <= shift_q;
    end
  end
endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_sel.sv
// TDR driving the firebird7_in_gate1 data mux: select bit nearest scan-in, data LSB at scan-out.
module firebird7_in_gate1_tessent_tdr_w19_sel
  import firebird7_in_gate1_tessent_pkg::*;
#(
  parameter int               WIDTH        = TDR_W19_WIDTH,
  parameter logic [WIDTH-1:0] DATA_RESET   = '0,
  parameter logic             SELECT_RESET = 1'b0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic             ijtag_so,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);
  logic [WIDTH:0] shift_q;
  logic [WIDTH:0] upd_q;

  genvar i;
  generate
    for (i = 0; i <= WIDTH; i++) begin : g_cell
      if (i == WIDTH) begin : g_sel
        // Select slice captures its own update value so the host can read back the mux select.
        firebird7_in_gate1_tessent_tdr_cell #(.RESET_VAL(SELECT_RESET)) u_cell (
          .clk(ijtag_tck), .reset(ijtag_reset), .sel(ijtag_sel),
          .ce(ijtag_ce), .se(ijtag_se), .ue(ijtag_ue),
          .si(ijtag_si), .cap(upd_q[i]),
          .shift_q(shift_q[i]), .upd_q(upd_q[i])
        );
      end else begin : g_data
        firebird7_in_gate1_tessent_tdr_cell #(.RESET_VAL(DATA_RESET[i])) u_cell (
          .clk(ijtag_tck), .reset(ijtag_reset), .sel(ijtag_sel),
          .ce(ijtag_ce), .se(ijtag_se), .ue(ijtag_ue),
          .si(shift_q[i+1]), .cap(capture_data_in[i]),
          .shift_q(shift_q[i]), .upd_q(upd_q[i])
        );
      end
    end
  endgenerate

  assign ijtag_so       = shift_q[0];
  assign ijtag_select   = upd_q[TDR_SEL_BIT];
  assign ijtag_data_out = upd_q[WIDTH-1:0];
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_sel.sv
// Directed + random checks of the w19 select TDR against a queue-based chain model.
module tb_firebird7_in_gate1_tessent_tdr_w19_sel;
  import firebird7_in_gate1_tessent_pkg::*;

  logic        tck = 1'b0;
  logic        rst, sel, ce, se, ue, si;
  logic [18:0] cap;
  logic        so, osel;
  logic [18:0] odata;

  int tests = 0;
  int fails = 0;

  // Model: the chain as a queue, entry 0 is the scan-out end.
  bit        mq[$];
  bit        msel;
  bit [18:0] mdata;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_tdr_w19_sel dut (
    .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(sel),
    .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si),
    .capture_data_in(cap), .ijtag_so(so),
    .ijtag_select(osel), .ijtag_data_out(odata)
  );

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit c, input bit sh,
                      input bit u, input bit i, input bit [18:0] d);
    bit oq[$];
    bit old_sel;
    rst = r; sel = s; ce = c; se = sh; ue = u; si = i; cap = d;
    @(posedge tck);
    oq = mq;
    old_sel = msel;
    if (r) begin
      mq = {};
      repeat (20) mq.push_back(1'b0);
      msel = 1'b0;
      mdata = '0;
    end else if (s) begin
      if (u) begin
        for (int k = 0; k < 19; k++) mdata[k] = oq[k];
        msel = oq[19];
      end
      if (c) begin
        mq = {};
        for (int k = 0; k < 19; k++) mq.push_back(d[k]);
        mq.push_back(old_sel);
      end else if (sh) begin
        void'(mq.pop_front());
        mq.push_back(i);
      end
    end
    #1;
    chk("so",     {19'b0, so},   {19'b0, mq[0]});
    chk("select", {19'b0, osel}, {19'b0, msel});
    chk("data",   {1'b0, odata}, {1'b0, mdata});
  endtask

  task automatic shift_in(input logic [19:0] pat);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 1, 0, pat[k], 19'($urandom));
  endtask

  initial begin
    tdr_w19_t img;
    logic [19:0] pat, cpat;

    // Reset with random enables
    repeat (2) step(1, $urandom, $urandom, $urandom, $urandom, $urandom, 19'($urandom));
    chk("rst_so", {19'b0, so}, 20'h0);
    chk("rst_out", {osel, odata}, 20'h0);

    // Shift {1,5A5A5} and update
    img.sel = 1'b1; img.data = 19'h5A5A5;
    shift_in(img);
    chk("pre_upd_out", {osel, odata}, 20'h0);
    step(0, 1, 0, 0, 1, 0, 19'h0);
    chk("upd_out", {osel, odata}, img);

    // Capture 7_1234 with select=1, then read it out
    cpat = {1'b1, 19'h71234};
    step(0, 1, 1, 0, 0, 0, 19'h71234);
    chk("cap_bit0", {19'b0, so}, {19'b0, cpat[0]});
    for (int k = 1; k < 20; k++) begin
      step(0, 1, 0, 1, 0, $urandom, 19'($urandom));
      chk($sformatf("cap_bit%0d", k), {19'b0, so}, {19'b0, cpat[k]});
    end

    // Deselected: everything ignored
    repeat (30) step(0, 0, $urandom, $urandom, $urandom, $urandom, 19'($urandom));
    chk("gate_out", {osel, odata}, img);

    // ce and se together: capture wins
    step(0, 1, 1, 1, 0, 1, 19'h00001);
    chk("ce_se_so", {19'b0, so}, 20'h1);

    // se and ue together: update loads the pre-shift image
    shift_in(20'hABCDE);
    step(0, 1, 0, 1, 1, 0, 19'h0);
    chk("se_ue_out", {osel, odata}, 20'hABCDE);

    // Reset mid-shift, then a fresh full pattern
    for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 0, $urandom, 19'h0);
    step(1, 1, 0, 1, 1, 1, 19'h0);
    chk("midrst_out", {osel, odata}, 20'h0);
    pat = 20'($urandom);
    shift_in(pat);
    step(0, 1, 0, 0, 1, 0, 19'h0);
    chk("midrst_new", {osel, odata}, pat);

    // Random traffic
    repeat (400)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 5) == 0),
           $urandom, 19'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
